// File: rtl/mul4_eval_sequencer.sv
// Scores one combinational mul4 candidate against the exact 32x32 product.
// Define BIT_SCORE_EN to score matching bits instead of matching words.
module mul4_eval_sequencer #(
  parameter int unsigned NUM_VECTORS   = 64,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [63:0] LFSR_SEED     = 64'h0000_0001_0000_0003
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [15:0] op_a1,
  output logic [15:0] op_a0,
  output logic [15:0] op_b1,
  output logic [15:0] op_b0,
  input  logic [15:0] ind_y3,
  input  logic [15:0] ind_y2,
  input  logic [15:0] ind_y1,
  input  logic [15:0] ind_y0,
  output logic        busy,
  output logic        done,
  output logic [31:0] score,
  output logic [15:0] perfect_cnt,
  output logic        score_valid
);

  localparam logic [63:0] SEED =
    (LFSR_SEED == 64'h0) ? 64'h1 : LFSR_SEED;
  localparam logic [15:0] NV_M1 = 16'(NUM_VECTORS - 1);
  localparam logic [31:0] SC_M1 = 32'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_DRIVE, S_SCORE, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] lfsr_q, lfsr_d;
  logic [15:0] vec_q, vec_d;
  logic [31:0] settle_q, settle_d;
  logic [31:0] score_q, score_d;
  logic [15:0] perf_q, perf_d;
  logic        valid_q, valid_d;

  logic [63:0] gold;
  logic [63:0] ind;
  logic [6:0]  match_n;
  logic        all_eq;
  logic        fb;
  logic [32:0] score_sum;
  logic [16:0] perf_sum;

  assign gold = 64'(lfsr_q[63:32]) * 64'(lfsr_q[31:0]);
  assign ind  = {ind_y3, ind_y2, ind_y1, ind_y0};
  assign all_eq = (ind == gold);
  assign fb = lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59];

`ifdef BIT_SCORE_EN
  always_comb begin
    match_n = '0;
    for (int i = 0; i < 64; i++) begin
      match_n = match_n + 7'(~(ind[i] ^ gold[i]));
    end
  end
`else
  always_comb begin
    match_n = 7'(ind_y0 == gold[15:0])
            + 7'(ind_y1 == gold[31:16])
            + 7'(ind_y2 == gold[47:32])
            + 7'(ind_y3 == gold[63:48]);
  end
`endif

  assign score_sum = {1'b0, score_q} + 33'(match_n);
  assign perf_sum  = {1'b0, perf_q} + 17'(all_eq);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    score_d  = score_q;
    perf_d   = perf_q;
    valid_d  = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_DRIVE;
          lfsr_d   = SEED;
          vec_d    = '0;
          settle_d = '0;
          score_d  = '0;
          perf_d   = '0;
          valid_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        settle_d = settle_q + 32'd1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (settle_q == SC_M1) begin
          state_d = S_SCORE;
        end
      end
      S_SCORE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          score_d  = score_sum[32] ? 32'hFFFF_FFFF
                                   : score_sum[31:0];
          perf_d   = perf_sum[16] ? 16'hFFFF
                                  : perf_sum[15:0];
          lfsr_d   = {lfsr_q[62:0], fb};
          vec_d    = vec_q + 16'd1;
          settle_d = '0;
          state_d  = (vec_q == NV_M1) ? S_DONE : S_DRIVE;
        end
      end
      S_DONE: begin
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      vec_q    <= '0;
      settle_q <= '0;
      score_q  <= '0;
      perf_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      score_q  <= score_d;
      perf_q   <= perf_d;
      valid_q  <= valid_d;
    end
  end

  assign op_a1       = lfsr_q[63:48];
  assign op_a0       = lfsr_q[47:32];
  assign op_b1       = lfsr_q[31:16];
  assign op_b0       = lfsr_q[15:0];
  assign busy        = (state_q == S_DRIVE) || (state_q == S_SCORE);
  assign done        = (state_q == S_DONE);
  assign score       = score_q;
  assign perfect_cnt = perf_q;
  assign score_valid = valid_q;

endmodule

// File: tb/tb_mul4_eval_sequencer.sv
// Randomised scoreboard bench for mul4_eval_sequencer.
// Candidate is a behavioural multiplier with optional word corruption.
module tb_mul4_eval_sequencer;

  localparam int NV  = 64;
  localparam int SC  = 1;
  localparam int LAT = NV * (SC + 1) + 1;
  localparam logic [63:0] SEED = 64'h0000_0001_0000_0003;
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
`ifdef BIT_SCORE_EN
  localparam int EXACT_SCORE = NV * 64;
`else
  localparam int EXACT_SCORE = NV * 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [15:0] op_a1, op_a0, op_b1, op_b0;
  logic [15:0] y3, y2, y1, y0;
  logic        busy, done, score_valid;
  logic [31:0] score;
  logic [15:0] perfect_cnt;

  int          mode;
  logic [31:0] key;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [31:0] sc;
    logic [15:0] pc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mul4_eval_sequencer #(
    .NUM_VECTORS(NV), .SETTLE_CYCLES(SC), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_a1(op_a1), .op_a0(op_a0), .op_b1(op_b1), .op_b0(op_b0),
    .ind_y3(y3), .ind_y2(y2), .ind_y1(y1), .ind_y0(y0),
    .busy(busy), .done(done), .score(score),
    .perfect_cnt(perfect_cnt), .score_valid(score_valid)
  );

  // mode 0: exact, 1: all zeros, 2: exact with keyed bit flips
  function automatic logic [63:0] cand(
    logic [31:0] a, logic [31:0] b, int m, logic [31:0] k);
    logic [63:0] p;
    logic [31:0] h;
    p = 64'(a) * 64'(b);
    h = a ^ b ^ k;
    if (m == 1) return 64'h0;
    if (m == 2) begin
      for (int i = 0; i < 4; i++) begin
        if (((h >> (4 * i)) & 32'h3) == 32'h0)
          p = p ^ (64'h1 << (16 * i + int'((b >> (4 * i)) & 32'hF)));
      end
    end
    return p;
  endfunction

  always_comb begin
    {y3, y2, y1, y0} = cand({op_a1, op_a0}, {op_b1, op_b0}, mode, key);
  end

  function automatic logic [63:0] step(logic [63:0] x);
    return (x << 1) | 64'(^(x & TAPS));
  endfunction

  function automatic exp_t model(int m, logic [31:0] k);
    exp_t        e;
    logic [63:0] x, g, y;
    longint      s;
    int          p;
    x = SEED;
    s = 0;
    p = 0;
    for (int v = 0; v < NV; v++) begin
      g = 64'(x[63:32]) * 64'(x[31:0]);
      y = cand(x[63:32], x[31:0], m, k);
`ifdef BIT_SCORE_EN
      s += $countones(~(y ^ g));
`else
      for (int w = 0; w < 4; w++)
        if (((y >> (16 * w)) & 64'hFFFF) == ((g >> (16 * w)) & 64'hFFFF))
          s++;
`endif
      if (y == g) p++;
      x = step(x);
    end
    if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
    if (p > 65535) p = 65535;
    e.sc = 32'(s);
    e.pc = 16'(p);
    return e;
  endfunction

  task automatic chk(string n, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("score", 64'(score), 64'(e.sc));
        chk("perfect_cnt", 64'(perfect_cnt), 64'(e.pc));
      end
    end
  end

  task automatic check_reset_vals(string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_score"}, 64'(score), 0);
    chk({tag, "_perfect"}, 64'(perfect_cnt), 0);
    chk({tag, "_valid"}, 64'(score_valid), 0);
    chk({tag, "_ops"}, {op_a1, op_a0, op_b1, op_b0}, SEED);
  endtask

  task automatic run_eval(int m, logic [31:0] k);
    int cnt, nbusy, badv;
    mode = m;
    key  = k;
    exp_q.push_back(model(m, k));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    nbusy = 0;
    badv = 0;
    while (done !== 1'b1 && cnt < 2000) begin
      if (busy) nbusy++;
      if (score_valid) badv++;
      @(negedge clk);
      cnt++;
    end
    chk("latency", 64'(cnt), 64'(LAT));
    chk("busy_cycles", 64'(nbusy), 64'(LAT - 1));
    chk("valid_low_in_run", 64'(badv), 0);
    chk("valid_at_done", 64'(score_valid), 0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 0);
    chk("valid_after_done", 64'(score_valid), 1);
    chk("busy_after_done", 64'(busy), 0);
  endtask

  initial begin
    int dcnt;
    int dt[$];
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    key   = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_eval(1, 32'h0);
    run_eval(0, 32'h0);
    chk("exact_score", 64'(score), 64'(EXACT_SCORE));
    chk("exact_perfect", 64'(perfect_cnt), 64'(NV));
    run_eval(0, 32'h0);
    chk("exact_score_rerun", 64'(score), 64'(EXACT_SCORE));
    repeat (4) run_eval(2, $urandom);

    // abort in the 10th SCORE cycle
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("busy_before_abort", 64'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_valid", 64'(score_valid), 0);
    dcnt = 0;
    repeat (6) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(dcnt), 0);
    run_eval(0, 32'h0);
    chk("post_abort_score", 64'(score), 64'(EXACT_SCORE));

    // reset during vector 20
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (41) @(negedge clk);
    chk("busy_before_reset", 64'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("midrun_reset");
    @(negedge clk);
    chk("reset_stays_idle", 64'(busy), 0);

    // start held high for 300 cycles
    mode = 0;
    exp_q.push_back(model(0, 32'h0));
    exp_q.push_back(model(0, 32'h0));
    start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (done) dt.push_back(c);
    end
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("held_done_count", 64'(dt.size()), 2);
    if (dt.size() == 2) begin
      chk("held_done_1", 64'(dt[0]), 64'(LAT));
      chk("held_done_2", 64'(dt[1]), 64'(2 * LAT + 1));
    end
    chk("held_abort_busy", 64'(busy), 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
